// File: rtl/axis_out_framer_pkg.sv
// Shared types and constants for the AXI-Stream output framer.
// Counter widths are derived from the image geometry via cnt_width().
package axis_out_framer_pkg;

  localparam int unsigned AxisDataWidth = 32;
  localparam int unsigned DstImgWidth   = 3840;
  localparam int unsigned DstImgHeight  = 2160;

  // Floor of 1 bit so a one-pixel or one-line geometry still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ColWidth = cnt_width(DstImgWidth);
  localparam int unsigned RowWidth = cnt_width(DstImgHeight);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } framer_state_e;

  typedef struct packed {
    logic [AxisDataWidth-1:0] data;
    logic                     tlast;
    logic                     tuser;
  } beat_t;

endpackage

// File: rtl/axis_out_framer_if.sv
// One AXI-Stream link: master drives payload and valid, slave drives ready.
interface axis_out_framer_if #(
  parameter int unsigned DataWidth = 32
) ();

  logic                 tvalid;
  logic                 tready;
  logic [DataWidth-1:0] tdata;
  logic                 tlast;
  logic                 tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer; reports its next-cycle occupancy so the owner can register ready.
module axis_skid_buf #(
  parameter int unsigned Width = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       count_next_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign out_valid_o  = (count_q != 2'd0);
  assign out_data_o   = mem_q[rd_ptr_q];
  assign count_next_o = count_d;

  // The write slot never aliases the head while valid, so the output holds during a stall.
  assign push = in_valid_i && (count_q != 2'd2);
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axis_out_framer.sv
// Re-frames the upscaled pixel stream: SOF/EOL from counters, 2-entry skid, frame_done pulse.
// Optional FRAMER_EOL_CHECK_EN: compare upstream tlast with regenerated EOL (sticky errors).
module axis_out_framer
  import axis_out_framer_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = AxisDataWidth,
  parameter int unsigned DST_IMG_WIDTH   = DstImgWidth,
  parameter int unsigned DST_IMG_HEIGHT  = DstImgHeight
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  axis_out_framer_if.slave  s_axis,
  axis_out_framer_if.master m_axis,
  output logic busy,
  output logic frame_done,
  output logic err_eol_early,
  output logic err_eol_late
);

  localparam int unsigned ColW    = cnt_width(DST_IMG_WIDTH);
  localparam int unsigned RowW    = cnt_width(DST_IMG_HEIGHT);
  localparam int unsigned BeatW   = AXIS_DATA_WIDTH + 2;
  localparam logic [ColW-1:0] LastCol = ColW'(DST_IMG_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(DST_IMG_HEIGHT - 1);

  framer_state_e    state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             tready_q, tready_d;
  logic             done_q, done_d;
  logic             in_fire, at_eol, at_sof;
  logic             skid_valid;
  logic [1:0]       skid_count_d;
  logic [BeatW-1:0] in_payload, out_payload;

  assign in_fire    = s_axis.tvalid && tready_q;
  assign at_eol     = (col_q == LastCol);
  assign at_sof     = (col_q == '0) && (row_q == '0);
  assign in_payload = {s_axis.tdata, at_eol, at_sof};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (in_fire) begin
          if (at_eol) begin
            col_d = '0;
            if (row_q == LastRow) state_d = StDrain;
            else                  row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!skid_valid) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Ready is registered from the buffer's post-move occupancy, so it can never overrun.
    tready_d = (state_d == StRun) && (skid_count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tready_q <= tready_d;
      done_q   <= done_d;
    end
  end

  axis_skid_buf #(
    .Width (BeatW)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_fire),
    .in_data_i    (in_payload),
    .out_valid_o  (skid_valid),
    .out_ready_i  (m_axis.tready),
    .out_data_o   (out_payload),
    .count_next_o (skid_count_d)
  );

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = skid_valid;
  assign m_axis.tdata  = out_payload[BeatW-1:2];
  assign m_axis.tlast  = out_payload[1];
  assign m_axis.tuser  = out_payload[0];
  assign busy          = (state_q != StIdle);
  assign frame_done    = done_q;

`ifdef FRAMER_EOL_CHECK_EN
  logic err_early_q, err_early_d;
  logic err_late_q, err_late_d;

  always_comb begin
    err_early_d = err_early_q;
    err_late_d  = err_late_q;
    if ((state_q == StIdle) && start) begin
      err_early_d = 1'b0;
      err_late_d  = 1'b0;
    end else if (in_fire) begin
      if (s_axis.tlast && !at_eol) err_early_d = 1'b1;
      if (!s_axis.tlast && at_eol) err_late_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
    end
  end

  assign err_eol_early = err_early_q;
  assign err_eol_late  = err_late_q;
`else
  assign err_eol_early = 1'b0;
  assign err_eol_late  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_out_framer.sv
// Bench for axis_out_framer at W=4, H=2: vector table of frame scenarios plus a
// cycle-level reference model (expected-beat queue and occupancy count) checked every cycle.
module tb_axis_out_framer;
  import axis_out_framer_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
`ifdef FRAMER_EOL_CHECK_EN
  localparam bit EolChk = 1'b1;
`else
  localparam bit EolChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, frame_done, err_eol_early, err_eol_late;

  axis_out_framer_if #(.DataWidth(32)) s_if ();
  axis_out_framer_if #(.DataWidth(32)) m_if ();

  axis_out_framer #(
    .AXIS_DATA_WIDTH (32),
    .DST_IMG_WIDTH   (W),
    .DST_IMG_HEIGHT  (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_eol_early (err_eol_early),
    .err_eol_late  (err_eol_late)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model state
  bit          mon_en = 1'b0;
  beat_t       exp_q[$];
  int          occ = 0, in_idx = 0, done_cnt = 0, hs_cnt = 0;
  bit          mbusy = 0, e_early = 0, e_late = 0, exp_done = 0, exp_tready = 0;
  bit          stalled = 0, nxt_done;
  logic [31:0] held_data;
  logic        held_last, held_user;
  beat_t       e;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, mbusy);
      chk("frame_done", frame_done, exp_done);
      chk("s_tready", s_if.tready, exp_tready);
      chk("m_tvalid", m_if.tvalid, occ != 0);
      chk("err_eol_early", err_eol_early, e_early);
      chk("err_eol_late", err_eol_late, e_late);
      if (stalled && m_if.tvalid) begin
        chk("stall_data", m_if.tdata, held_data);
        chk("stall_tlast", m_if.tlast, held_last);
        chk("stall_tuser", m_if.tuser, held_user);
      end
      if (frame_done) done_cnt++;
      if (rst) begin
        mbusy = 0; occ = 0; in_idx = 0; exp_q.delete();
        e_early = 0; e_late = 0; exp_done = 0; exp_tready = 0;
      end else begin
        nxt_done = mbusy && (in_idx == N) && (occ == 0);
        if (nxt_done) mbusy = 0;
        else if (start && !mbusy) begin
          mbusy = 1; in_idx = 0; e_early = 0; e_late = 0;
        end
        if (m_if.tvalid && m_if.tready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_beat: got %0h want none (t=%0t)", m_if.tdata, $time);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_if.tdata, e.data);
            chk("out_tlast", m_if.tlast, e.tlast);
            chk("out_tuser", m_if.tuser, e.tuser);
          end
          if (occ > 0) occ--;
        end
        if (s_if.tvalid && s_if.tready) begin
          e.data  = s_if.tdata;
          e.tlast = (in_idx % W) == W - 1;
          e.tuser = (in_idx == 0);
          if (EolChk && s_if.tlast && !e.tlast) e_early = 1;
          if (EolChk && !s_if.tlast && e.tlast) e_late = 1;
          exp_q.push_back(e);
          in_idx++;
          occ++;
        end
        exp_done   = nxt_done;
        exp_tready = mbusy && (in_idx < N) && (occ < 2);
      end
      stalled   = m_if.tvalid && !m_if.tready && !rst;
      held_data = m_if.tdata;
      held_last = m_if.tlast;
      held_user = m_if.tuser;
    end
  end

  typedef struct {
    int in_mode;   // 0 always valid, sequential data; 1 random valid, random data
    int out_mode;  // 0 always ready; 1 toggle 1010; 2 random
    int tl_mode;   // 0 correct tlast; 1 early on beat 2, missing on beat 7; 2 random
    int start_at;  // beat index at which a stray start is pulsed, -1 none
    int rst_at;    // assert rst once this many beats are accepted, -1 none
    int exp_done;
    bit chk_err;
    bit exp_early;
    bit exp_late;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] next_data(input int mode, input int b);
    return (mode == 0) ? 32'(b) : $urandom;
  endfunction

  function automatic logic tlast_for(input int mode, input int b);
    if (mode == 1 && b == 2) return 1'b1;
    if (mode == 1 && b == 7) return 1'b0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (b % W) == W - 1;
  endfunction

  function automatic logic ready_for(input int mode, input bit tog);
    if (mode == 1) return tog;
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic run_frame(input vec_t v);
    int beat, budget, d0, h0;
    bit tog, dup_done, acc;
    logic [31:0] cur;
    logic cur_tl;
    d0 = done_cnt; h0 = hs_cnt;
    s_if.tvalid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beat = 0; budget = 400; tog = 1'b1; dup_done = 1'b0;
    cur = next_data(v.in_mode, 0);
    cur_tl = tlast_for(v.tl_mode, 0);
    while (beat < N && budget > 0) begin
      if (v.rst_at >= 0 && beat == v.rst_at) break;
      s_if.tvalid = (v.in_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_if.tdata  = cur;
      s_if.tlast  = cur_tl;
      m_if.tready = ready_for(v.out_mode, tog);
      tog = ~tog;
      start = (beat == v.start_at) && !dup_done;
      if (start) dup_done = 1'b1;
      @(negedge clk);
      acc = s_if.tvalid && s_if.tready;
      @(posedge clk); #1;
      if (acc) begin
        beat++;
        cur = next_data(v.in_mode, beat);
        cur_tl = tlast_for(v.tl_mode, beat);
      end
      budget--;
    end
    start = 1'b0;
    s_if.tvalid = 1'b0;
    chk("input_budget", budget == 0, 1'b0);
    if (v.rst_at >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk("rst_m_tdata", m_if.tdata, 32'h0);
      chk("rst_m_tlast", m_if.tlast, 1'b0);
      chk("rst_m_tuser", m_if.tuser, 1'b0);
      chk("rst_s_tready", s_if.tready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_beats_taken", beat, v.rst_at);
      @(posedge clk); #1;
    end else begin
      budget = 200;
      while (done_cnt == d0 && budget > 0) begin
        m_if.tready = ready_for(v.out_mode, tog);
        tog = ~tog;
        @(posedge clk); #1;
        budget--;
      end
      m_if.tready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("frames_done", done_cnt - d0, v.exp_done);
      chk("beats_out", hs_cnt - h0, N);
      if (v.chk_err) begin
        chk("frame_err_early", err_eol_early, v.exp_early);
        chk("frame_err_late", err_eol_late, v.exp_late);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[1]  = '{0, 1, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[2]  = '{0, 0, 0,  3, -1, 1, 1, 1'b0, 1'b0};
    vecs[3]  = '{0, 0, 1, -1, -1, 1, 1, EolChk, EolChk};
    vecs[4]  = '{0, 1, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[5]  = '{0, 1, 0, -1,  6, 0, 0, 1'b0, 1'b0};
    vecs[6]  = '{0, 0, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[7]  = '{1, 2, 2, -1, -1, 1, 0, 1'b0, 1'b0};
    vecs[8]  = '{1, 1, 2, -1, -1, 1, 0, 1'b0, 1'b0};
    vecs[9]  = '{0, 2, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[10] = '{1, 0, 2, -1, -1, 1, 0, 1'b0, 1'b0};
    vecs[11] = '{1, 2, 0, -1, -1, 1, 1, 1'b0, 1'b0};
    vecs[12] = '{0, 2, 2, -1, -1, 1, 0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_m_tvalid", m_if.tvalid, 1'b0);
    chk("reset_m_tdata", m_if.tdata, 32'h0);
    chk("reset_m_tlast", m_if.tlast, 1'b0);
    chk("reset_m_tuser", m_if.tuser, 1'b0);
    chk("reset_s_tready", s_if.tready, 1'b0);
    chk("reset_err_early", err_eol_early, 1'b0);
    chk("reset_err_late", err_eol_late, 1'b0);

    // Valid without start must never be accepted.
    @(posedge clk); #1;
    s_if.tvalid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("nostart_s_tready", s_if.tready, 1'b0);
      chk("nostart_m_tvalid", m_if.tvalid, 1'b0);
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_frame(vecs[i]);
    end

    chk("leftover_beats", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
